// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, through one fa_cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             s, c;
  logic             accept, last;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // A 1-bit sum register has no upper bits to shift down.
  if (WIDTH == 1) begin : g_w1
    always_comb sum_nxt = s;
  end else begin : g_wn
    always_comb sum_nxt = {s, sum_sh[WIDTH-1:1]};
  end

  assign accept = start_valid && start_ready;
  assign last   = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done_valid  = 1'b1;
        start_ready = done_ready;
        if (done_ready) state_nxt = start_valid ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic cmsb_q;
`endif

  // sum/cout come from dedicated result registers so they hold the last
  // result while the shift registers are reused for the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sum_sh <= sum_nxt;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= c;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q  <= sum_nxt;
        cout_q <= c;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_q <= carry;
`endif
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = cmsb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8).
// Define SERIAL_ADDER_OVF_EN to also exercise the overflow output.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done_valid, done_ready;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands and take the accepting edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input string tag);
    a = ta; b = tb_; cin = tc; start_valid = 1'b1;
    check({tag, " start_ready"}, start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Edge count includes the accepting edge.
  task automatic wait_done(input string tag);
    int n;
    n = 1;
    while (!done_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 9);
  endtask

  task automatic release_result(input string tag);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check({tag, " done_valid drop"}, done_valid, 0);
    check({tag, " idle ready"}, start_ready, 1);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input string tag);
    start_op(ta, tb_, tc, tag);
    wait_done(tag);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, ovf, eo);
`else
    if (eo !== eo) $display("unused");
`endif
    release_result(tag);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst start_ready", start_ready, 1);
    check("rst busy", busy, 0);
    check("rst done_valid", done_valid, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst ovf", ovf, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x0F + 0x01, then backpressure with ignored operands on the input.
    start_op(8'h0F, 8'h01, 1'b0, "op0f");
    check("op0f busy", busy, 1);
    wait_done("op0f");
    check("op0f sum", sum, 8'h10);
    check("op0f cout", cout, 0);
    a = 8'h55; b = 8'h55; cin = 1'b1; start_valid = 1'b1; done_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp sum", sum, 8'h10);
      check("bp cout", cout, 0);
      check("bp done_valid", done_valid, 1);
      check("bp start_ready", start_ready, 0);
      check("bp busy", busy, 0);
    end

    // Back-to-back: release and new accept on the same edge.
    a = 8'h03; b = 8'h04; cin = 1'b0; done_ready = 1'b1;
    #1;
    check("b2b start_ready", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0; done_ready = 1'b0;
    check("b2b busy", busy, 1);
    check("b2b done_valid", done_valid, 0);
    wait_done("b2b");
    check("b2b sum", sum, 8'h07);
    check("b2b cout", cout, 0);
    release_result("b2b");

    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff+01");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff+ff+1");

    // Reset during the third SHIFT cycle.
    start_op(8'h12, 8'h34, 1'b1, "rstmid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid in shift", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid busy", busy, 0);
    check("rstmid done_valid", done_valid, 0);
    check("rstmid sum", sum, 0);
    check("rstmid cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid start_ready", start_ready, 1);
    run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "after rst");

`ifdef SERIAL_ADDER_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf 7f+01");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ovf ff+01");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
